// File: rtl/path_delay_meter_if.sv
// Handshake and result bundle for path_delay_meter; the slave modport is the meter side.
// The master modport belongs to the controller that pulses start and drives the chain output.
interface path_delay_meter_if #(
  parameter int CNT_W       = 12,
  parameter int TRIALS_LOG2 = 4
);
  logic                         start;
  logic                         pathResult;
  logic                         pathLaunch;
  logic                         busy;
  logic                         done;
  logic                         timeout;
  logic [CNT_W+TRIALS_LOG2-1:0] delaySum;
  logic [CNT_W-1:0]             delayMin;
  logic [CNT_W-1:0]             delayMax;

  modport master (
    output start, pathResult,
    input  pathLaunch, busy, done, timeout, delaySum, delayMin, delayMax
  );

  modport slave (
    input  start, pathResult,
    output pathLaunch, busy, done, timeout, delaySum, delayMin, delayMax
  );
endinterface

// File: rtl/path_delay_meter.sv
// Times 2^TRIALS_LOG2 alternating-edge launches through a delay path; min/max tracking only with DELAY_MINMAX_EN.
// busy rises one cycle after an accepted start; start is ignored outside IDLE, no other backpressure.
module path_delay_meter #(
  parameter int CNT_W       = 12,
  parameter int TRIALS_LOG2 = 4,
  parameter int TIMEOUT     = 4000,
  parameter int SETTLE_CYC  = 8,
  parameter bit PATH_INV    = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  path_delay_meter_if.slave bus
);
  localparam int SUM_W = CNT_W + TRIALS_LOG2;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_RECORD, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d, sync2_q, sync2_d;
  logic                   launch_q, launch_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       trial_q, trial_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [TRIALS_LOG2-1:0] idx_q, idx_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic                   tmo_q, tmo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   res_s, exp_lvl;

  assign res_s   = sync2_q;
  assign exp_lvl = launch_q ^ PATH_INV;

  always_comb begin
    state_d  = state_q;
    sync1_d  = bus.pathResult;
    sync2_d  = sync1_q;
    launch_d = launch_q;
    cnt_d    = cnt_q;
    trial_d  = trial_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    tmo_d    = tmo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sum_d    = '0;
          tmo_d    = 1'b0;
          idx_d    = '0;
          settle_d = '0;
          busy_d   = 1'b1;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (res_s == exp_lvl) begin
          if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
            settle_d = '0;
            launch_d = ~launch_q;
            cnt_d    = CNT_W'(1);
            state_d  = S_MEASURE;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end else begin
          settle_d = '0;
        end
      end
      S_MEASURE: begin
        // A match wins over the limit when both land in the same cycle.
        if (res_s == exp_lvl) begin
          trial_d = cnt_q;
          state_d = S_RECORD;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          trial_d = cnt_q;
          tmo_d   = 1'b1;
          state_d = S_RECORD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RECORD: begin
        sum_d = sum_q + {{TRIALS_LOG2{1'b0}}, trial_q};
        if (idx_q == '1) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + TRIALS_LOG2'(1);
          state_d = S_SETTLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      launch_q <= 1'b0;
      cnt_q    <= '0;
      trial_q  <= '0;
      settle_q <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      tmo_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      launch_q <= launch_d;
      cnt_q    <= cnt_d;
      trial_q  <= trial_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef DELAY_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
  logic             run_clr, rec_en;

  assign run_clr = (state_q == S_IDLE) && bus.start;
  assign rec_en  = (state_q == S_RECORD);

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (run_clr) begin
      min_d = '1;
      max_d = '0;
    end else if (rec_en) begin
      if (trial_q < min_q) min_d = trial_q;
      if (trial_q > max_q) max_d = trial_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign bus.delayMin = min_q;
  assign bus.delayMax = max_q;
`else
  assign bus.delayMin = '0;
  assign bus.delayMax = '0;
`endif

  assign bus.pathLaunch = launch_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = tmo_q;
  assign bus.delaySum   = sum_q;
endmodule
